// File: rtl/sd_block_seq_pkg.sv
// Shared types and constants for the SD single-block request sequencer.
package sd_block_seq_pkg;

  typedef enum logic [3:0] {
    StIdle, StArg0, StArg1, StArg2, StArg3, StBufLo, StCsr,
    StCmd, StStart, StGap, StPoll, StAbort, StDone
  } state_e;

  // CSR bit positions
  localparam int unsigned SYNC_RESET = 0;
  localparam int unsigned START      = 1;
  localparam int unsigned INC_ADDR   = 2;
  localparam int unsigned RESP_LSB   = 3;
  localparam int unsigned RESP_MSB   = 4;
  localparam int unsigned FAST       = 5;
  localparam int unsigned BUFHI_LSB  = 6;
  localparam int unsigned BUFHI_MSB  = 7;

  localparam logic [5:0] CMD_DONE_MARK = 6'h3F;
  localparam logic [1:0] STATUS_ABORT  = 2'b11;

  function automatic logic [7:0] csr_word(input logic [1:0] buf_hi, input logic fast,
                                          input logic [1:0] resp, input logic start);
    logic [7:0] w;
    w                      = '0;
    w[BUFHI_MSB:BUFHI_LSB] = buf_hi;
    w[FAST]                = fast;
    w[RESP_MSB:RESP_LSB]   = resp;
    w[START]               = start;
    return w;
  endfunction

endpackage

// File: rtl/sd_block_seq.sv
// Sequences ARG/BUF/CSR/CMD register writes for one SD block transfer, then polls CMD
// for the completion mark, with abort and poll-timeout handling.
module sd_block_seq
  import sd_block_seq_pkg::*;
#(
  parameter logic [7:0]  REG_ADDR_CSR      = 8'd0,
  parameter logic [7:0]  REG_ADDR_CMD      = 8'd1,
  parameter logic [7:0]  REG_ADDR_ARG0     = 8'd2,
  parameter logic [7:0]  REG_ADDR_ARG1     = 8'd3,
  parameter logic [7:0]  REG_ADDR_ARG2     = 8'd4,
  parameter logic [7:0]  REG_ADDR_ARG3     = 8'd5,
  parameter logic [7:0]  REG_ADDR_BUF_ADDR = 8'd6,
  parameter logic [5:0]  CMD_READ          = 6'd17,
  parameter logic [5:0]  CMD_WRITE         = 6'd24,
  parameter logic [1:0]  RESP_TYPE         = 2'b00,
  parameter logic        SCLK_FAST         = 1'b1,
  parameter bit          BYTE_ADDR         = 1'b0,
  parameter int unsigned TIMEOUT_CYCLES    = 2 ** 22
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_i,
  input  logic        req_wr_i,
  input  logic [31:0] lba_i,
  input  logic [9:0]  buf_base_i,
  input  logic        abort_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [1:0]  status_o,
  output logic        timeout_o,
  output logic        stb_o,
  output logic        we_o,
  output logic [7:0]  adr_wr_o,
  output logic [7:0]  adr_rd_o,
  output logic [7:0]  dat_o,
  input  logic [7:0]  dat_i
);

  localparam logic [22:0] TimeoutLimit = 23'(TIMEOUT_CYCLES);

  state_e      state_q, state_d;
  logic [31:0] lba_q, lba_d;
  logic [9:0]  buf_q, buf_d;
  logic        wr_q, wr_d;
  logic [22:0] cnt_q, cnt_d;
  logic        gap_q, gap_d;
  logic [7:0]  smp_q, smp_d;
  logic        smp_vld_q, smp_vld_d;
  logic        timed_out_q, timed_out_d;
  logic [1:0]  status_q, status_d;
  logic        timeout_q, timeout_d;

  logic [31:0] arg;
  logic        match;
  logic        abortable;

  assign arg   = BYTE_ADDR ? {lba_q[22:0], 9'd0} : lba_q;
  assign match = smp_vld_q && (smp_q[5:0] == CMD_DONE_MARK);

  always_comb begin
    state_d     = state_q;
    lba_d       = lba_q;
    buf_d       = buf_q;
    wr_d        = wr_q;
    cnt_d       = cnt_q;
    gap_d       = gap_q;
    timed_out_d = timed_out_q;
    status_d    = status_q;
    timeout_d   = timeout_q;
    smp_d       = smp_q;
    smp_vld_d   = (state_q == StPoll);
    stb_o       = 1'b0;
    we_o        = 1'b0;
    adr_wr_o    = '0;
    dat_o       = '0;
    abortable   = 1'b1;

    unique case (state_q)
      StIdle: begin
        abortable = 1'b0;
        if (req_i) begin
          lba_d       = lba_i;
          buf_d       = buf_base_i;
          wr_d        = req_wr_i;
          timed_out_d = 1'b0;
          state_d     = StArg0;
        end
      end
      StArg0:  begin stb_o = 1'b1; we_o = 1'b1; adr_wr_o = REG_ADDR_ARG0; dat_o = arg[7:0];
                     state_d = StArg1; end
      StArg1:  begin stb_o = 1'b1; we_o = 1'b1; adr_wr_o = REG_ADDR_ARG1; dat_o = arg[15:8];
                     state_d = StArg2; end
      StArg2:  begin stb_o = 1'b1; we_o = 1'b1; adr_wr_o = REG_ADDR_ARG2; dat_o = arg[23:16];
                     state_d = StArg3; end
      StArg3:  begin stb_o = 1'b1; we_o = 1'b1; adr_wr_o = REG_ADDR_ARG3; dat_o = arg[31:24];
                     state_d = StBufLo; end
      StBufLo: begin stb_o = 1'b1; we_o = 1'b1; adr_wr_o = REG_ADDR_BUF_ADDR;
                     dat_o = buf_q[7:0]; state_d = StCsr; end
      StCsr: begin
        stb_o    = 1'b1;
        we_o     = 1'b1;
        adr_wr_o = REG_ADDR_CSR;
        dat_o    = csr_word(buf_q[9:8], SCLK_FAST, RESP_TYPE, 1'b0);
        state_d  = StCmd;
      end
      StCmd: begin
        stb_o    = 1'b1;
        we_o     = 1'b1;
        adr_wr_o = REG_ADDR_CMD;
        dat_o    = {2'b00, (wr_q ? CMD_WRITE : CMD_READ)};
        state_d  = StStart;
      end
      StStart: begin
        stb_o    = 1'b1;
        we_o     = 1'b1;
        adr_wr_o = REG_ADDR_CSR;
        dat_o    = csr_word(buf_q[9:8], SCLK_FAST, RESP_TYPE, 1'b1);
        gap_d    = 1'b0;
        state_d  = StGap;
      end
      // Two idle cycles so the register block's CMD readback reflects the start write.
      StGap: begin
        gap_d = ~gap_q;
        cnt_d = '0;
        if (gap_q) state_d = StPoll;
      end
      StPoll: begin
        stb_o = 1'b1;
        smp_d = dat_i;
        if (match) begin
          status_d  = smp_q[7:6];
          timeout_d = 1'b0;
          state_d   = StDone;
        end else if (cnt_q >= TimeoutLimit) begin
          timed_out_d = 1'b1;
          state_d     = StAbort;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 23'd1;
        end
      end
      StAbort: begin
        stb_o     = 1'b1;
        we_o      = 1'b1;
        adr_wr_o  = REG_ADDR_CSR;
        dat_o     = 8'(1 << SYNC_RESET);
        status_d  = STATUS_ABORT;
        timeout_d = timed_out_q;
        state_d   = StDone;
      end
      StDone: begin
        abortable = 1'b0;
        state_d   = StIdle;
      end
      default: begin
        abortable = 1'b0;
        state_d   = StIdle;
      end
    endcase

    // A completion seen in the same cycle as abort_i takes priority.
    if (abort_i && abortable && (state_q != StAbort) && !(state_q == StPoll && match)) begin
      state_d = StAbort;
    end
  end

  assign adr_rd_o  = REG_ADDR_CMD;
  assign busy_o    = (state_q != StIdle) && (state_q != StDone);
  assign done_o    = (state_q == StDone);
  assign status_o  = status_q;
  assign timeout_o = timeout_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      lba_q       <= '0;
      buf_q       <= '0;
      wr_q        <= 1'b0;
      cnt_q       <= '0;
      gap_q       <= 1'b0;
      smp_q       <= '0;
      smp_vld_q   <= 1'b0;
      timed_out_q <= 1'b0;
      status_q    <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      lba_q       <= lba_d;
      buf_q       <= buf_d;
      wr_q        <= wr_d;
      cnt_q       <= cnt_d;
      gap_q       <= gap_d;
      smp_q       <= smp_d;
      smp_vld_q   <= smp_vld_d;
      timed_out_q <= timed_out_d;
      status_q    <= status_d;
      timeout_q   <= timeout_d;
    end
  end

endmodule

// File: tb/tb_sd_block_seq.sv
// Self-checking bench: two sequencer instances (LBA and byte addressing) run in lockstep
// against a register-block slave model and a write-list reference model.
module tb_sd_block_seq;

  localparam int   T       = 100;
  localparam logic TB_FAST = 1'b0;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  logic        req_i = 1'b0, req_wr_i = 1'b0, abort_i = 1'b0;
  logic [31:0] lba_i = '0;
  logic [9:0]  buf_base_i = '0;
  logic [7:0]  dat_i;

  logic       a_busy, a_done, a_timeout, a_stb, a_we, b_busy, b_done, b_timeout, b_stb, b_we;
  logic [1:0] a_status, b_status;
  logic [7:0] a_adr_wr, a_adr_rd, a_dat, b_adr_wr, b_adr_rd, b_dat;

  sd_block_seq #(.SCLK_FAST(TB_FAST), .BYTE_ADDR(1'b0), .TIMEOUT_CYCLES(T)) dut_a (
    .clk(clk), .reset_n(reset_n), .req_i(req_i), .req_wr_i(req_wr_i), .lba_i(lba_i),
    .buf_base_i(buf_base_i), .abort_i(abort_i), .busy_o(a_busy), .done_o(a_done),
    .status_o(a_status), .timeout_o(a_timeout), .stb_o(a_stb), .we_o(a_we),
    .adr_wr_o(a_adr_wr), .adr_rd_o(a_adr_rd), .dat_o(a_dat), .dat_i(dat_i)
  );

  sd_block_seq #(.SCLK_FAST(TB_FAST), .BYTE_ADDR(1'b1), .TIMEOUT_CYCLES(T)) dut_b (
    .clk(clk), .reset_n(reset_n), .req_i(req_i), .req_wr_i(req_wr_i), .lba_i(lba_i),
    .buf_base_i(buf_base_i), .abort_i(abort_i), .busy_o(b_busy), .done_o(b_done),
    .status_o(b_status), .timeout_o(b_timeout), .stb_o(b_stb), .we_o(b_we),
    .adr_wr_o(b_adr_wr), .adr_rd_o(b_adr_rd), .dat_o(b_dat), .dat_i(dat_i)
  );

  int          errors = 0;
  int          checks = 0;
  int          poll_n = 0;
  int          poll_base = 0;
  int          resp_delay = 1000;
  logic [7:0]  resp_val = 8'h00;
  logic [7:0]  idle_val = 8'h00;
  logic [15:0] wq_a[$];
  logic [15:0] wq_b[$];

  // Slave: CMD reads show the done mark once resp_delay poll reads have been served.
  always_comb begin
    if ((a_adr_rd == 8'd1) && ((poll_n - poll_base) > resp_delay)) dat_i = resp_val;
    else dat_i = idle_val;
  end

  always @(negedge clk) begin
    if (a_stb && a_we) wq_a.push_back({a_adr_wr, a_dat});
    if (b_stb && b_we) wq_b.push_back({b_adr_wr, b_dat});
    if (a_stb && !a_we) poll_n <= poll_n + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference write list for a full request, index 0..7 in issue order.
  function automatic logic [15:0] exp_write(input bit ba, input bit wr, input logic [31:0] lba,
                                            input logic [9:0] bufb, input int idx);
    logic [31:0] arg;
    logic [7:0]  csr;
    arg = ba ? lba * 32'd512 : lba;
    csr = {bufb[9:8], 6'd0} + (TB_FAST ? 8'd32 : 8'd0);
    case (idx)
      0:       return {8'd2, arg[7:0]};
      1:       return {8'd3, arg[15:8]};
      2:       return {8'd4, arg[23:16]};
      3:       return {8'd5, arg[31:24]};
      4:       return {8'd6, bufb[7:0]};
      5:       return {8'd0, csr};
      6:       return {8'd1, (wr ? 8'd24 : 8'd17)};
      default: return {8'd0, csr + 8'd2};
    endcase
  endfunction

  // Called at posedge+1; raises req_i this cycle. abort_at = cycle index (1 = first ARG write).
  task automatic run_req(input bit wr, input logic [31:0] lba, input logic [9:0] bufb,
                         input int delay, input logic [1:0] st, input int abort_at,
                         input bit hold);
    int wa, wb, cyc, m, nw, exp_done;
    bit aborted, exp_to, got_done;
    logic [1:0] exp_st;
    wa         = wq_a.size();
    wb         = wq_b.size();
    poll_base  = poll_n;
    resp_delay = delay;
    resp_val   = {st, 6'h3F};
    idle_val   = {2'($urandom), 6'($urandom_range(0, 62))};
    req_i      = 1'b1;
    req_wr_i   = wr;
    lba_i      = lba;
    buf_base_i = bufb;
    m = 12 + delay;  // cycle in which the registered sample shows the mark
    if (abort_at > 0 && abort_at < m) begin
      aborted = 1; exp_to = 0; exp_st = 2'b11; exp_done = abort_at + 2;
      nw = (abort_at < 8) ? abort_at : 8;
    end else if (m <= 11 + T) begin
      aborted = 0; exp_to = 0; exp_st = st; exp_done = m + 1; nw = 8;
    end else begin
      aborted = 1; exp_to = 1; exp_st = 2'b11; exp_done = 13 + T; nw = 8;
    end
    cyc = 0;
    got_done = 0;
    while (cyc < 400 && !got_done) begin
      @(posedge clk); #1;
      cyc++;
      if (!hold) req_i = 1'b0;
      abort_i = (cyc == abort_at);
      if (cyc == 1) begin
        chk("busy_a_accept", a_busy, 1);
        chk("busy_b_accept", b_busy, 1);
      end
      if (a_done) got_done = 1;
    end
    abort_i = 1'b0;
    req_i   = 1'b0;
    chk("done_seen", got_done, 1);
    if (got_done) begin
      if (exp_to) chk("timeout_latency", (cyc >= 12 + T) && (cyc <= 14 + T), 1);
      else chk("done_latency", cyc, exp_done);
      chk("done_b", b_done, 1);
      chk("status_a", a_status, exp_st);
      chk("status_b", b_status, exp_st);
      chk("timeout_a", a_timeout, exp_to);
      chk("timeout_b", b_timeout, exp_to);
      chk("busy_at_done", a_busy, 0);
    end
    chk("nwrites_a", wq_a.size() - wa, nw + int'(aborted));
    chk("nwrites_b", wq_b.size() - wb, nw + int'(aborted));
    if (wq_a.size() - wa == nw + int'(aborted) && wq_b.size() - wb == nw + int'(aborted)) begin
      for (int i = 0; i < nw; i++) begin
        chk($sformatf("write_a[%0d]", i), wq_a[wa + i], exp_write(1'b0, wr, lba, bufb, i));
        chk($sformatf("write_b[%0d]", i), wq_b[wb + i], exp_write(1'b1, wr, lba, bufb, i));
      end
      if (aborted) chk("sync_reset_write", wq_a[wa + nw], 16'h0001);
    end
    @(posedge clk); #1;
    chk("done_pulse_width", a_done, 0);
    chk("status_held", a_status, exp_st);
    chk("idle_not_busy", a_busy, 0);
  endtask

  initial begin
    int cnt;
    #1 reset_n = 1'b0;
    #2;
    chk("rst_busy", a_busy, 0);
    chk("rst_done", a_done, 0);
    chk("rst_stb", a_stb, 0);
    chk("rst_we", a_we, 0);
    chk("rst_status", a_status, 0);
    chk("rst_timeout", a_timeout, 0);
    chk("rst_adr_rd", a_adr_rd, 8'd1);
    chk("rst_adr_wr", a_adr_wr, 0);
    chk("rst_dat", a_dat, 0);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;

    run_req(1'b0, 32'h0000_1234, 10'h2A5, 50, 2'b00, 0, 1'b0);
    // Literal sequence from the read example, issued by the LBA-addressed instance.
    chk("lit_buf", wq_a[wq_a.size() - 4], 16'h06A5);
    chk("lit_csr", wq_a[wq_a.size() - 3], 16'h0080);
    chk("lit_cmd", wq_a[wq_a.size() - 2], 16'h0111);
    chk("lit_start", wq_a[wq_a.size() - 1], 16'h0082);
    run_req(1'b1, 32'h0000_0001, 10'h013, 10, 2'b01, 0, 1'b0);
    chk("lit_b_arg1", wq_b[wq_b.size() - 7], 16'h0302);
    chk("lit_b_cmd", wq_b[wq_b.size() - 2], 16'h0118);
    run_req(1'b0, 32'hDEAD_BEEF, 10'h3FF, 1000, 2'b00, 0, 1'b0);

    // Asynchronous reset in the middle of a poll.
    req_i = 1'b1; req_wr_i = 1'b1; lba_i = 32'h55; buf_base_i = 10'h1;
    poll_base = poll_n; resp_delay = 1000;
    @(posedge clk); #1;
    req_i = 1'b0;
    repeat (19) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    chk("arst_busy", a_busy, 0);
    chk("arst_stb", a_stb, 0);
    chk("arst_we", a_we, 0);
    chk("arst_done", a_done, 0);
    chk("arst_status", a_status, 0);
    chk("arst_timeout", a_timeout, 0);
    chk("arst_adr_rd", a_adr_rd, 8'd1);
    chk("arst_b_busy", b_busy, 0);
    @(negedge clk) reset_n = 1'b1;
    cnt = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (a_done || b_done || a_busy) cnt++;
    end
    chk("no_done_after_reset", cnt, 0);

    run_req(1'b1, 32'h0000_0777, 10'h155, 20, 2'b10, 3, 1'b0);
    run_req(1'b0, 32'h0102_0304, 10'h0F0, 4, 2'b11, 0, 1'b1);
    run_req(1'b1, 32'h00AB_CDEF, 10'h2C3, 0, 2'b01, 0, 1'b0);
    run_req(1'b0, 32'h0000_0042, 10'h100, 5, 2'b10, 17, 1'b0);
    run_req(1'b1, 32'h0000_0042, 10'h100, 40, 2'b00, 10, 1'b0);

    for (int k = 0; k < 10; k++) begin
      int d, ab;
      d  = $urandom_range(0, 30);
      ab = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 12 + d) : 0;
      run_req(1'($urandom_range(0, 1)), $urandom, 10'($urandom_range(0, 1023)), d,
              2'($urandom_range(0, 3)), ab, 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sd_block_seq.md
# sd_block_seq

Hardware sequencer that turns a single-block read or write request (LBA plus buffer base) into the register-write and poll sequence of the SD-card SPI register block on its 8-bit FASM-style register port. It sits between a host-side requester (DMA or CPU-offload logic) and that register port, so software no longer bit-bangs ARG/CMD/CSR writes and polls for completion. One request is in flight at a time.

## Interface
- `REG_ADDR_CSR`, default 0: CSR register address.
- `REG_ADDR_CMD`, default 1: CMD register address.
- `REG_ADDR_ARG0`..`REG_ADDR_ARG3`, defaults 2..5: argument byte addresses, ARG0 = LSB.
- `REG_ADDR_BUF_ADDR`, default 6: buffer address low byte.
- `CMD_READ`, default 17: command index for read.
- `CMD_WRITE`, default 24: command index for write.
- `RESP_TYPE`, default 2'b00: value for CSR[4:3].
- `SCLK_FAST`, default 1: value for CSR[5].
- `BYTE_ADDR`, default 0: 1 sends `lba<<9` (SDSC); 0 sends `lba` (SDHC).
- `TIMEOUT_CYCLES`, default 2**22: maximum poll duration before abort.
- `clk`, input, 1: clock.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `req_i`, input, 1: start a request; sampled only in IDLE.
- `req_wr_i`, input, 1: 1 = write block, 0 = read block.
- `lba_i`, input, 32: block address; captured with `req_i`.
- `buf_base_i`, input, 10: buffer base address; captured with `req_i`.
- `abort_i`, input, 1: abort the in-flight request.
- `busy_o`, output, 1: high from acceptance until `done_o`.
- `done_o`, output, 1: one-cycle completion pulse.
- `status_o`, output, 2: returned status; valid with `done_o` and held afterwards.
- `timeout_o`, output, 1: set with `done_o` when the poll timed out.
- `stb_o`, output, 1: register-port strobe.
- `we_o`, output, 1: register-port write enable.
- `adr_wr_o`, output, 8: write address.
- `adr_rd_o`, output, 8: read address.
- `dat_o`, output, 8: write data.
- `dat_i`, input, 8: read data, combinational from `adr_rd_o`; `{ret_status[1:0], cmd[5:0]}` when reading CMD.

## Operation
- States: IDLE, W_ARG0, W_ARG1, W_ARG2, W_ARG3, W_BUFLO, W_CSR, W_CMD, W_START, GAP, POLL, ABORT, DONE.
- IDLE:
  - On `req_i`, capture `lba_i`, `buf_base_i` and `req_wr_i`, set `busy_o`, go to W_ARG0.
  - `req_i` in any other state is ignored. It is not queued.
- Each W_* state lasts exactly one cycle with `stb_o`=`we_o`=1:
  - W_ARG0..W_ARG3 write the argument bytes ARG0..ARG3 (LSB first).
  - W_BUFLO writes `buf_base[7:0]`.
  - W_CSR writes `{buf_base[9:8], SCLK_FAST, RESP_TYPE, 3'b000}`, which sets the buffer high bits with no start bit.
  - W_CMD writes `{2'b00, cmd}`, where cmd = `CMD_WRITE` if write, else `CMD_READ`.
  - W_START writes `{buf_base[9:8], SCLK_FAST, RESP_TYPE, 3'b010}`, which pulses start.
- GAP: two idle cycles with `stb_o`=0. This covers the one-cycle registered write path in the register block before a CMD readback is valid.
- POLL:
  - Drive `stb_o`=1, `we_o`=0, `adr_rd_o`=`REG_ADDR_CMD`, and register `dat_i` each cycle.
  - When the registered value has `[5:0]`==6'h3F, latch `status_o`=`[7:6]` and go to DONE.
  - A 23-bit cycle counter, cleared on entry to POLL, reaching `TIMEOUT_CYCLES` sets `timeout_o` and goes to ABORT.
- ABORT:
  - Entered from timeout or from `abort_i` in any non-IDLE, non-DONE state.
  - One write of CSR = 8'h01 (sync_reset), then DONE with `status_o`=2'b11.
- DONE: pulse `done_o` for one cycle, clear `busy_o`, return to IDLE.
- `abort_i` and the completion match in the same cycle: completion wins.

## Timing
- Reset values:
  - All outputs are 0 except `adr_rd_o`, which resets to `REG_ADDR_CMD`.
  - The state machine resets to IDLE.
  - Captured registers reset to 0.
- Accepted request to first ARG write: 1 cycle.
- `req_i` cycle to the W_START write: 8 cycles.
- Poll latency: the first CMD sample occurs 3 cycles after W_START.
- A match detected in POLL cycle n gives `done_o` in cycle n+2, because of the registered sample.
- Asynchronous reset mid-sequence returns to IDLE immediately. No sync_reset write is issued, so the owner must also reset the register block.
- The timeout counter saturates and does not wrap.

## Structure
- Package `sd_block_seq_pkg`:
  - State enum.
  - CSR bit-position constants: SYNC_RESET=0, START=1, INC_ADDR=2, RESP=4:3, FAST=5, BUFHI=7:6.
  - `CMD_DONE_MARK`=6'h3F.
  - `STATUS_ABORT`=2'b11.
- Sub-modules: none. This is a single module of about 200 lines.

## Test plan
- Read, `lba`=32'h0000_1234, `buf_base`=10'h2A5, `BYTE_ADDR`=0 -> write sequence ARG 34,12,00,00; BUF 0xA5; CSR 0x80; CMD 0x11; CSR 0x82. Slave model returns 8'h3F after 50 cycles -> `done_o`, `status_o`=0.
- Write with `BYTE_ADDR`=1, `lba`=1 -> ARG bytes 00,02,00,00; CMD 0x18. Slave returns 8'h7F -> `status_o`=2'b01.
- Slave never returns 0x3F, `TIMEOUT_CYCLES`=100 -> CSR 0x01 written, `timeout_o`=1, `status_o`=2'b11.
- `abort_i` during W_ARG2 -> next write is CSR 0x01, then `done_o`, `status_o`=2'b11.
- `req_i` held during `busy_o` -> exactly one sequence is issued. A new `req_i` the cycle after `done_o` is accepted.
- `reset_n` asserted during POLL -> all outputs are at reset values asynchronously, `busy_o`=0, and there is no `done_o`.
